// File: rtl/fpu_add_result_buffer.sv
// Result buffer behind the single-precision FPU adder.
// Every adder result pulse goes into a first-word-fall-through FIFO. The
// FIFO head is presented to the consumer with a valid/ready handshake.
// An in-flight counter lets the upstream issuer send an add only when a FIFO
// slot is guaranteed to be free for its result. Sticky flags report misuse
// and NaN results, for debug.
module fpu_add_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              issue_fire,
  output logic              credit_avail,
  input  logic              result_tvalid,
  input  logic [DATA_W-1:0] result_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  in_flight,
  input  logic              err_clr,
  output logic              overflow,
  output logic              credit_err,
  output logic              orphan_err,
  output logic              nan_seen
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  // The credit sum needs one extra bit: in_flight + count can reach 2*DEPTH
  // under illegal use.
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam int FLAG_N = 4;

  // Bit positions of the sticky flags in the packed flag vector.
  localparam int F_OVERFLOW = 0;
  localparam int F_CREDIT   = 1;
  localparam int F_ORPHAN   = 2;
  localparam int F_NAN      = 3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CNT_W-1:0]  in_flight_reg, in_flight_next;
  logic [FLAG_N-1:0] flag_reg;
  logic [FLAG_N-1:0] flag_set;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic wr_en;
  logic inc;
  logic dec;
  logic push_is_nan;
  logic [CNT_W:0] credit_sum;

  // The handshake is driven from registered state only. m_tdata comes straight
  // from the array, so the head is visible in the cycle after its write.
  assign m_tvalid = (count_reg != '0);
  assign m_tdata  = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign in_flight = in_flight_reg;

  // Credit depends only on registered counters. This keeps issue_fire free of
  // any combinational path from the consumer or from the adder.
  assign credit_sum   = {1'b0, in_flight_reg} + {1'b0, count_reg};
  assign credit_avail = (credit_sum < DEPTH_SUM);

  assign push   = result_tvalid;
  assign pop    = m_tvalid & m_tready;
  assign full   = (count_reg == DEPTH_CNT);
  // When the FIFO is full, a push is stored only if the head leaves in the same cycle.
  assign accept = push & (~full | pop);
  assign wr_en  = accept & ~areset;

  assign inc = issue_fire & credit_avail;
  assign dec = result_tvalid & (in_flight_reg != '0);

  // A NaN has an all-ones exponent and a non-zero mantissa. An infinity has a
  // zero mantissa and does not count as a NaN.
  assign push_is_nan = (result_tdata[30:23] == 8'hFF) && (result_tdata[22:0] != 23'd0);

  // Next-state computation for the pointers and for both counters.
  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    in_flight_next = in_flight_reg;

    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end

    if (accept && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !accept) begin
      count_next = count_reg - CNT_W'(1);
    end

    if (inc && !dec) begin
      in_flight_next = in_flight_reg + CNT_W'(1);
    end else if (dec && !inc) begin
      in_flight_next = in_flight_reg - CNT_W'(1);
    end
  end

  // Set conditions for each sticky flag in this cycle.
  always_comb begin
    flag_set             = '0;
    flag_set[F_OVERFLOW] = push & ~accept;
    flag_set[F_CREDIT]   = issue_fire & ~credit_avail;
    flag_set[F_ORPHAN]   = result_tvalid & (in_flight_reg == '0);
    flag_set[F_NAN]      = accept & push_is_nan;
  end

  // Register the pointers and counters. Reset drops anything that is pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      in_flight_reg <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      in_flight_reg <= in_flight_next;
    end
  end

  // FIFO storage. It has no reset, so it can map onto distributed or block memory.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= result_tdata;
    end
  end

  // Sticky flags. In the same cycle, a new event takes priority over err_clr.
  generate
    for (genvar gi = 0; gi < FLAG_N; gi++) begin : g_flag
      always_ff @(posedge aclk) begin
        if (areset) begin
          flag_reg[gi] <= 1'b0;
        end else if (flag_set[gi]) begin
          flag_reg[gi] <= 1'b1;
        end else if (err_clr) begin
          flag_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign overflow   = flag_reg[F_OVERFLOW];
  assign credit_err = flag_reg[F_CREDIT];
  assign orphan_err = flag_reg[F_ORPHAN];
  assign nan_seen   = flag_reg[F_NAN];

endmodule

// File: doc/fpu_add_result_buffer.md
Name: fpu_add_result_buffer

Overview:
- Downstream stage of the single-precision FPU adder wrapper. Captures every adder result pulse (result_tvalid/result_tdata, which carry no backpressure) into a first-word-fall-through FIFO.
- Re-presents the results to the consumer with a valid/ready handshake.
- Tracks operations in flight so the issuer upstream of the adder only issues when a FIFO slot is guaranteed for the result. Raises sticky error and NaN flags for debug.

Parameters:
- DATA_W, 32, result width; matches adder result_tdata.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and in-flight counters.

Ports:
- aclk  in  1  rising-edge clock, shared with the adder.
- areset  in  1  synchronous, active-high reset.
- issue_fire  in  1  one add issued to the adder this cycle (a/b tvalid driven high).
- credit_avail  out  1  issuer may assert issue_fire this cycle.
- result_tvalid  in  1  adder result valid pulse.
- result_tdata  in  DATA_W  adder result.
- m_tvalid  out  1  head entry valid.
- m_tready  in  1  consumer accepts head.
- m_tdata  out  DATA_W  head entry.
- count  out  CNT_W  FIFO occupancy.
- in_flight  out  CNT_W  issued adds not yet returned.
- err_clr  in  1  clears the sticky flags.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- credit_err  out  1  sticky: issue_fire asserted while credit_avail=0.
- orphan_err  out  1  sticky: a result arrived while in_flight=0.
- nan_seen  out  1  sticky: a NaN result was stored.

Behaviour:
- Reset (areset=1 at a clock edge):
  - rd_ptr, wr_ptr, count, in_flight and all sticky flags clear to 0; m_tvalid=0; credit_avail=1.
  - FIFO memory is not reset.
  - Reset has priority over all other inputs in that cycle; in-flight results are forgotten.
- Push and pop:
  - push = result_tvalid.
  - pop = m_tvalid & m_tready.
  - m_tvalid = (count != 0); m_tdata = mem[rd_ptr]. Both are driven combinationally from registered state.
- Latency: a result presented at edge N is visible on m_tvalid/m_tdata after edge N. There is no same-cycle bypass.
- Accept rule: the push is stored if count<DEPTH or pop=1 in the same cycle.
  - Full with simultaneous push and pop: the head leaves, the new entry is written, count stays DEPTH.
  - Otherwise, while full, the result is dropped and overflow is set.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Occupancy: count +1 on accepted push only, -1 on pop only, unchanged on both or neither.
- In-flight accounting (inc = issue_fire & credit_avail, dec = result_tvalid & in_flight!=0):
  - inc only: in_flight +1; dec only: in_flight -1; both: unchanged.
  - issue_fire while credit_avail=0: no increment, credit_err set.
  - result_tvalid while in_flight=0: orphan_err set; the data is still pushed under the accept rule.
- Credit:
  - credit_avail = (in_flight + count) < DEPTH, computed from registered values only; it must not depend on issue_fire, m_tready or result_tvalid in the same cycle.
  - A pop frees credit from the next cycle onward.
  - Under legal use, in_flight+count never exceeds DEPTH, so overflow stays 0.
- nan_seen: set when an accepted push has bits[30:23]=8'hFF and bits[22:0]!=0. Infinities (mantissa 0) do not set it.
- Sticky flags:
  - err_clr=1 clears all four flags at the edge.
  - If a set condition and err_clr occur in the same cycle, the set wins.
- Empty: pop with m_tvalid=0 is impossible by definition; m_tready is ignored.
- Data ordering: strictly FIFO; results leave in the order the adder produced them.

Test Plan (DEPTH=4):
- Reset:
  - Stimulus: hold areset 2 cycles with result_tvalid=1.
  - Required: count=0, in_flight=0, m_tvalid=0, credit_avail=1, all flags 0, nothing stored.
- Credit throttle:
  - Stimulus: issue_fire 4 consecutive cycles, m_tready=0, no results.
  - Required: in_flight=4 and credit_avail=0 after edge 4. A 5th issue_fire sets credit_err and in_flight stays 4.
- Ordered return:
  - Stimulus: 4 results 3F800000, 40000000, 40400000, 40800000 returned one per cycle, then m_tready=1.
  - Required: count reaches 4, in_flight reaches 0, m_tdata emerges in that order over 4 cycles, then m_tvalid=0 and credit_avail=1.
- Full with simultaneous push and pop:
  - Stimulus: count=4, result_tvalid=1 with 41000000, m_tready=1.
  - Required: head popped, count stays 4, 41000000 emerges last, overflow=0.
  - Stimulus: repeat with m_tready=0.
  - Required: result dropped, overflow=1, count=4.
- Orphan and NaN:
  - Stimulus: with in_flight=0, push 7FC00000.
  - Required: orphan_err=1, nan_seen=1, entry stored.
  - Stimulus: push 7F800000.
  - Required: nan_seen is not set by this entry.
  - Stimulus: err_clr with no new events.
  - Required: all flags 0 next cycle.
- Wrap-around:
  - Stimulus: stream 10 results with m_tready=1 every cycle.
  - Required: count toggles 0/1, data is in order across the pointer wrap, m_tvalid lags each push by 1 cycle.
